// File: rtl/pc_unit.sv
// Fetch program counter: reset vector, stall hold, flush/branch redirect,
// and a held branch that survives a stall until the next unstalled edge.
module pc_unit #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0,
    parameter int                 STEP       = 4,
    parameter int                 ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        ctrl_signal,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] MASK =
        ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(STEP);

    typedef enum logic [1:0] {
        S_OFF,
        S_RUN,
        S_PEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_pend;
    logic [ADDR_W-1:0] w_pend_nxt;
    logic              r_mis;
    logic              w_mis_nxt;
    logic              w_stall;
    logic              w_unused_ctrl;

    assign w_stall       = ctrl_signal[0];
    assign w_unused_ctrl = ^ctrl_signal[5:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_pc    <= RESET_VEC;
            r_pend  <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    // Priority chain: OFF, flush, stall, held branch, new branch, step.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_mis_nxt   = 1'b0;
        if (r_state == S_OFF) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = RESET_VEC;
        end else if (flush) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = flush_pc & ~MASK;
            w_mis_nxt   = |(flush_pc & MASK);
            w_pend_nxt  = '0;
        end else if (w_stall) begin
            if (branch_flag) begin
                w_state_nxt = S_PEND;
                w_pend_nxt  = branch_target;
            end
        end else if (r_state == S_PEND) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = r_pend & ~MASK;
            w_mis_nxt   = |(r_pend & MASK);
        end else if (branch_flag) begin
            w_pc_nxt  = branch_target & ~MASK;
            w_mis_nxt = |(branch_target & MASK);
        end else begin
            w_pc_nxt = r_pc + INC;
        end
    end

    always_comb begin
        ce       = (r_state != S_OFF);
        pc       = r_pc;
        misalign = r_mis;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model pushes the expected
// outputs for each driven edge; they are popped and compared after it.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  ctrl_signal;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        ce;
    logic        misalign;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_signal   (ctrl_signal),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .pc            (pc),
        .ce            (ce),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic        m_on  = 1'b0;
    logic [31:0] m_pc  = 32'h0;
    logic        m_pv  = 1'b0;
    logic [31:0] m_pt  = 32'h0;
    logic        m_mis = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        m_pc  = {t[31:2], 2'b00};
        m_mis = (t[1:0] != 2'b00);
    endtask

    task automatic model(input logic r, input logic [5:0] c,
                         input logic f, input logic [31:0] fp,
                         input logic b, input logic [31:0] bt);
        m_mis = 1'b0;
        if (r) begin
            m_on = 1'b0;
            m_pc = 32'h0;
            m_pv = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1;
            m_pc = 32'h0;
        end else if (f) begin
            redirect(fp);
            m_pv = 1'b0;
        end else if (c[0]) begin
            if (b) begin
                m_pv = 1'b1;
                m_pt = bt;
            end
        end else if (m_pv) begin
            redirect(m_pt);
            m_pv = 1'b0;
        end else if (b) begin
            redirect(bt);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input string tag, input logic r,
                        input logic [5:0] c, input logic f,
                        input logic [31:0] fp, input logic b,
                        input logic [31:0] bt);
        exp_t e;
        rst           = r;
        ctrl_signal   = c;
        flush         = f;
        flush_pc      = fp;
        branch_flag   = b;
        branch_target = bt;
        model(r, c, f, fp, b, bt);
        sb.push_back('{pc: m_pc, ce: m_on, mis: m_mis});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, pc, e.pc);
            chk({tag, "_ce"}, {31'd0, ce}, {31'd0, e.ce});
            chk({tag, "_mis"}, {31'd0, misalign}, {31'd0, e.mis});
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        ctrl_signal   = 6'b0;
        flush         = 1'b0;
        flush_pc      = 32'h0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;

        // Reset and release
        step("rst", 1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("rst", 1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("tp_rst_ce", {31'd0, ce}, 32'd0);
        chk("tp_rst_pc", pc, 32'h0);
        run("rel", 1);
        chk("tp_rel_ce", {31'd0, ce}, 32'd1);
        chk("tp_rel_pc", pc, 32'h0);
        run("inc", 3);
        chk("tp_inc_pc", pc, 32'hC);

        // Stall hold, including the other ctrl bits
        run("to10", 1);
        step("stall", 1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
        step("stall", 1'b0, 6'b001111, 1'b0, 32'h0, 1'b0, 32'h0);
        step("stall", 1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("tp_stall_pc", pc, 32'h10);
        step("hi_bits", 1'b0, 6'b111110, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("tp_unstall_pc", pc, 32'h14);

        // Branch held across a stall
        run("to20", 3);
        step("bstall", 1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h100);
        step("bstall", 1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h100);
        chk("tp_bstall_pc", pc, 32'h20);
        step("bapply", 1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        chk("tp_bapply_pc", pc, 32'h100);
        run("bnext", 1);
        chk("tp_bnext_pc", pc, 32'h104);

        // Flush beats stall, branch and a held branch
        step("pend", 1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h300);
        step("flush", 1'b0, 6'b000001, 1'b1, 32'h180, 1'b1, 32'h340);
        chk("tp_flush_pc", pc, 32'h180);
        run("fnext", 1);
        chk("tp_fnext_pc", pc, 32'h184);

        // Misaligned branch target
        step("mis", 1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h203);
        chk("tp_mis_pc", pc, 32'h200);
        chk("tp_mis_flag", {31'd0, misalign}, 32'd1);
        run("misnext", 1);
        chk("tp_misnext_pc", pc, 32'h204);
        chk("tp_misnext_flag", {31'd0, misalign}, 32'd0);

        // Wrap, then reset while a branch is held
        step("wrapb", 1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        run("wrap", 1);
        chk("tp_wrap_pc", pc, 32'h0);
        step("pend2", 1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h500);
        step("rstp", 1'b1, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h500);
        chk("tp_rstp_ce", {31'd0, ce}, 32'd0);
        chk("tp_rstp_pc", pc, 32'h0);
        run("rstrel", 2);
        chk("tp_rstrel_pc", pc, 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 49) == 0),
                 6'($urandom_range(0, 63)),
                 ($urandom_range(0, 9) == 0),
                 $urandom(),
                 ($urandom_range(0, 3) == 0),
                 $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the instruction-fetch stage. It generates the fetch address and the instruction-memory enable, and redirects the fetch on exception flushes and on branches. Unlike the fixed 32-bit fetch counter, it has a configurable reset vector, width and step. A branch that arrives while fetch is stalled is held and applied later instead of being lost. It sits between the ctrl stall/flush logic and the instruction ROM; its outputs feed the ROM and the IF/ID register.

## Interface
- ADDR_W, 32, width of pc and of all target inputs
- RESET_VEC, 32'h0000_0000, first fetch address after reset; must be STEP-aligned
- STEP, 4, increment per unstalled cycle, in bytes; must be a power of two
- ALIGN_BITS, 2, number of low address bits that must be zero, equal to log2(STEP)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- ctrl_signal  in  6  stall vector from ctrl; bit0 set means the PC stage is stalled; other bits are ignored
- flush  in  1  exception/eret redirect; overrides everything
- flush_pc  in  ADDR_W  flush target
- branch_flag  in  1  taken branch/jump from ID
- branch_target  in  ADDR_W  branch destination
- pc  out  ADDR_W  current fetch address (registered)
- ce  out  1  instruction-memory chip enable (registered)
- misalign  out  1  one-cycle pulse: the last applied redirect target had nonzero low bits

## Operation
- States:
  - OFF: ce=0.
  - RUN: ce=1, nothing pending.
  - PEND: ce=1, a branch is held.
- Per-edge priority, highest first:
  1. rst
  2. state OFF
  3. flush
  4. stall (ctrl_signal[0]=1)
  5. applied pending branch
  6. branch_flag
  7. increment
- rst=1: go to OFF. ce<=0, pc<=RESET_VEC, misalign<=0, pending cleared.
- OFF with rst=0: ce<=1, pc<=RESET_VEC, go to RUN. The first fetch is at RESET_VEC.
- flush=1: pc<=flush_pc with the low ALIGN_BITS cleared. Pending is discarded and the state goes to RUN. This applies even while stalled.
- Stall with branch_flag=1: pc holds. branch_target is captured into the pending register and the state goes to PEND. A newer branch during the stall overwrites the held one.
- Stall without a branch: pc holds and the state is unchanged.
- Unstalled in PEND: pc<=pending target (aligned), go to RUN. A simultaneous branch_flag is ignored because it is the repeated stalled branch.
- Unstalled in RUN with branch_flag=1: pc<=branch_target (aligned).
- Otherwise: pc<=pc+STEP, modulo 2^ADDR_W. 0xFFFF_FFFC+4 wraps to 0 with no flag.
- Alignment: every redirect (flush, branch, pending) clears the low ALIGN_BITS. misalign<=1 on that edge if any cleared bit was set; otherwise misalign<=0 every edge.
- ctrl_signal bits [5:1] have no effect. Patterns 6'b000111 and 6'b001111 simply hold pc, because bit0=1.

## Timing
- Reset values: ce=0, pc=RESET_VEC, misalign=0, state OFF, pending empty.
- Reset to fetch: ce rises on the first edge with rst=0, and pc is RESET_VEC from that edge on. RESET_VEC+STEP follows one edge later if unstalled.
- Redirect latency: a flush or branch sampled at edge N is visible on pc after edge N. There are no bubbles inside this block.
- A held branch appears on pc after the first unstalled edge.
- rst mid-operation (in PEND or during a stall) overrides everything on that edge. Pending is lost and ce drops the next cycle.
- Flush and branch in the same cycle: flush wins and the branch is dropped.
- Flush during a stall with a pending branch: pc<=flush_pc and pending is cleared.
- A stall lasting any number of cycles holds pc exactly, with no drift.

## Test plan
- Reset release: rst 1→0 with defaults → ce=0 and pc=0 while in reset. After the first edge, ce=1 and pc=0x0. Then pc=0x4, 0x8, 0xC on consecutive edges.
- Stall hold: ctrl_signal=6'b000111 for 3 cycles at pc=0x10 → pc stays 0x10 for 3 cycles, then 0x14.
- Branch during stall: at pc=0x20, stall 2 cycles with branch_flag=1, branch_target=0x100 → pc stays 0x20. On the first unstalled edge pc=0x100, then 0x104.
- Flush priority: flush=1, flush_pc=0x180, together with branch_flag=1 and stall=1 → pc=0x180 on the next edge and pending is cleared. Releasing the stall then gives 0x184.
- Misaligned target: branch_target=0x203 unstalled → pc=0x200, misalign=1 for exactly one cycle, then pc=0x204 with misalign=0.
- Wrap and mid-run reset: pc=0xFFFF_FFFC → 0x0. Assert rst while in PEND → pc=RESET_VEC and ce=0 on that edge, and the pending target is never fetched.
